mod_mult_unit: RTL and testbench
================================

Name: mod_mult_unit

Overview:
- Multi-cycle modular multiplier: computes result = (a * b) mod q for the polynomial-arithmetic datapath.
- It is the responder side of the start/result_ready handshake that sequencing controllers use to issue multiply operations.
- Bit-serial interleaved modular multiplication: one multiplier bit per cycle, MSB first, so no wide product register is needed.

Parameters:
- DATA_WIDTH, 32, width of operands, modulus and result.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request pulse; operands sampled in the same cycle.
- a  input  DATA_WIDTH  multiplicand; must satisfy a < modulus.
- b  input  DATA_WIDTH  multiplier; any value (used bitwise).
- modulus  input  DATA_WIDTH  q; must satisfy q >= 2.
- result  output  DATA_WIDTH  (a*b) mod q; held until the next accepted start completes.
- result_ready  output  1  one-cycle pulse; result is valid in that cycle.
- busy  output  1  high while the state is CALC.
- error  output  1  qualifies result_ready; high when the operands were rejected.

Behaviour:
- Interface decision: one clock (clock); reset (reset) is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - result = 0, result_ready = 0, busy = 0, error = 0.
  - Internal registers acc, a_reg, b_reg, q_reg and cnt are all cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - start = 0: remain in IDLE.
  - start = 1 with a < modulus and modulus >= 2:
    - Latch a_reg = a, b_reg = b, q_reg = modulus.
    - Set acc = 0 and cnt = DATA_WIDTH-1.
    - Go to CALC.
  - start = 1 with a >= modulus or modulus < 2:
    - Set result = 0 and error = 1.
    - Go to DONE without calculating.
- CALC, one step per cycle, with acc held at DATA_WIDTH+1 bits internally:
  - t = 2*acc; if t >= q_reg then t = t - q_reg.
  - If b_reg[cnt] = 1: t = t + a_reg; if t >= q_reg then t = t - q_reg.
  - acc = t.
  - cnt != 0: decrement cnt and stay in CALC.
  - cnt == 0: result = t[DATA_WIDTH-1:0], error = 0, go to DONE.
- DONE:
  - result_ready = 1 for exactly this cycle; error is valid in this cycle.
  - Next state is IDLE.
  - A start in DONE is ignored; the requester issues start only after it has observed result_ready.
- Latency for valid operands:
  - start in cycle 0; CALC occupies cycles 1..DATA_WIDTH; result_ready is high in cycle DATA_WIDTH+1.
  - Throughput: one operation per DATA_WIDTH+2 cycles.
- Latency for rejected operands: result_ready and error are high in cycle 1.
- Invariant: acc < q_reg after every step. The internal width of DATA_WIDTH+1 bits covers 2*acc and acc + a_reg, both < 2q.
- busy = 1 exactly while in CALC.
- A start during CALC or DONE is ignored: no operand re-latch and no effect on the pending result.
- Operand inputs are don't-care except in the start cycle; changing them mid-operation has no effect.
- Reset asserted mid-operation: return to IDLE immediately with all outputs cleared; no result_ready pulse is produced for the aborted operation.
- result and error hold their values after DONE until overwritten by the next accepted operation.

Test Plan:
- Reset, then start with a=1234, b=2345, modulus=3329:
  - busy high for 32 cycles.
  - result_ready single pulse in cycle 33 with result=829, error=0.
- Start with a=3328, b=3328, modulus=3329 -> result=1. Start with a=5, b=0, modulus=3329 -> result=0.
- Start with a=0xFFFFFFFA, b=0xFFFFFFFF, modulus=0xFFFFFFFB -> result=0xFFFFFFF7, error=0. This checks that no overflow occurs at full width.
- Start with a=3329, modulus=3329 -> result_ready and error high in cycle 1, result=0. Start with modulus=1 -> same rejection.
- Start pulses during CALC, and operands changed mid-operation, using a=1234, b=2345, modulus=3329 -> still exactly one result_ready, result=829.
- Assert reset in cycle 10 of an operation -> outputs 0 and no result_ready pulse. A subsequent start with a=2, b=3, modulus=7 -> result=6.

Source files
------------

// File: rtl/mod_mult_unit.sv
// Bit-serial interleaved modular multiplier: result = (a * b) mod modulus.
// One multiplier bit is consumed per cycle, MSB first, so no wide product register is needed.
module mod_mult_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulus,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_ready,
    output logic                  busy,
    output logic                  error
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [DATA_WIDTH:0]   r_acc;
    logic [DATA_WIDTH-1:0] r_aReg;
    logic [DATA_WIDTH-1:0] r_bReg;
    logic [DATA_WIDTH-1:0] r_qReg;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_reject;
    logic [DATA_WIDTH:0]   w_qExt;
    logic [DATA_WIDTH:0]   w_dbl;
    logic [DATA_WIDTH:0]   w_t1;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_t2;

    assign w_accept = start && (a < modulus) && (modulus >= DATA_WIDTH'(2));
    assign w_reject = start && !w_accept;

    // Since acc < q, both 2*acc and t + a stay below 2q, so one conditional subtraction suffices.
    assign w_qExt = {1'b0, r_qReg};
    assign w_dbl  = r_acc << 1;
    assign w_t1   = (w_dbl >= w_qExt) ? (w_dbl - w_qExt) : w_dbl;
    assign w_sum  = w_t1 + {1'b0, r_aReg};
    assign w_t2   = r_bReg[r_cnt] ? ((w_sum >= w_qExt) ? (w_sum - w_qExt) : w_sum) : w_t1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = CALC;
                end else if (w_reject) begin
                    w_nextState = DONE;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state == CALC);
        result_ready = (r_state == DONE);
        result       = r_result;
        error        = r_error;
    end

    // Operands are only latched from IDLE, so starts during CALC or DONE cannot disturb a pending result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_aReg   <= '0;
            r_bReg   <= '0;
            r_qReg   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_aReg <= a;
                        r_bReg <= b;
                        r_qReg <= modulus;
                        r_acc  <= '0;
                        r_cnt  <= CNT_W'(DATA_WIDTH - 1);
                    end else if (w_reject) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end
                end
                CALC: begin
                    r_acc <= w_t2;
                    if (r_cnt == '0) begin
                        r_result <= w_t2[DATA_WIDTH-1:0];
                        r_error  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mult_unit.sv
// Directed self-checking bench for mod_mult_unit; expected values are worked out by hand.
module tb_mod_mult_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] modulus;
    logic [31:0] result;
    logic        result_ready;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;

    int          readyCycle;
    int          busyCycles;
    int          pulses;
    logic [31:0] res;
    logic        err;

    mod_mult_unit #(.DATA_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .a            (a),
        .b            (b),
        .modulus      (modulus),
        .result       (result),
        .result_ready (result_ready),
        .busy         (busy),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issues one start pulse, then watches a fixed 40-cycle window. With disturb set,
    // extra starts and garbage operands are driven in cycles 3..6 of the operation.
    task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] iq,
                                 input bit disturb,
                                 output int rdyCyc, output int busyCyc, output int nPulse,
                                 output logic [31:0] oRes, output logic oErr);
        @(negedge clock);
        a = ia; b = ib; modulus = iq; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        rdyCyc = -1; busyCyc = 0; nPulse = 0; oRes = 'x; oErr = 1'bx;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (busy === 1'b1) busyCyc++;
            if (result_ready === 1'b1) begin
                nPulse++;
                if (rdyCyc < 0) begin
                    rdyCyc = cyc;
                    oRes   = result;
                    oErr   = error;
                end
            end
            if (disturb && cyc >= 3 && cyc <= 6) begin
                start = 1'b1; a = $urandom; b = $urandom; modulus = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; modulus = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_ready", result_ready, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_error", error, 0);
        reset = 1'b0;

        applyStimulus(32'd1234, 32'd2345, 32'd3329, 1'b0, readyCycle, busyCycles, pulses, res, err);
        checkOutput("basic_ready_cycle", readyCycle, 33);
        checkOutput("basic_busy_cycles", busyCycles, 32);
        checkOutput("basic_pulses", pulses, 1);
        checkOutput("basic_result", res, 829);
        checkOutput("basic_error", err, 0);
        checkOutput("basic_result_held", result, 829);

        applyStimulus(32'd3328, 32'd3328, 32'd3329, 1'b0, readyCycle, busyCycles, pulses, res, err);
        checkOutput("qm1_squared_result", res, 1);
        checkOutput("qm1_squared_error", err, 0);

        applyStimulus(32'd5, 32'd0, 32'd3329, 1'b0, readyCycle, busyCycles, pulses, res, err);
        checkOutput("b_zero_result", res, 0);
        checkOutput("b_zero_ready_cycle", readyCycle, 33);

        applyStimulus(32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, readyCycle, busyCycles, pulses, res, err);
        checkOutput("full_width_result", res, 64'hFFFF_FFF7);
        checkOutput("full_width_error", err, 0);

        applyStimulus(32'd1234, 32'd2345, 32'd3329, 1'b0, readyCycle, busyCycles, pulses, res, err);
        checkOutput("prereject_result", res, 829);

        applyStimulus(32'd3329, 32'd7, 32'd3329, 1'b0, readyCycle, busyCycles, pulses, res, err);
        checkOutput("reject_a_ready_cycle", readyCycle, 1);
        checkOutput("reject_a_error", err, 1);
        checkOutput("reject_a_result", res, 0);
        checkOutput("reject_a_busy_cycles", busyCycles, 0);
        checkOutput("reject_a_pulses", pulses, 1);

        applyStimulus(32'd0, 32'd5, 32'd1, 1'b0, readyCycle, busyCycles, pulses, res, err);
        checkOutput("reject_q_ready_cycle", readyCycle, 1);
        checkOutput("reject_q_error", err, 1);
        checkOutput("reject_q_result", res, 0);

        applyStimulus(32'd1234, 32'd2345, 32'd3329, 1'b1, readyCycle, busyCycles, pulses, res, err);
        checkOutput("disturb_pulses", pulses, 1);
        checkOutput("disturb_ready_cycle", readyCycle, 33);
        checkOutput("disturb_result", res, 829);
        checkOutput("disturb_error", err, 0);

        @(negedge clock);
        a = 32'd1234; b = 32'd2345; modulus = 32'd3329; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("abort_result", result, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready", result_ready, 0);
        checkOutput("abort_error", error, 0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (result_ready === 1'b1) pulses++;
            @(negedge clock);
        end
        checkOutput("abort_no_pulse", pulses, 0);

        applyStimulus(32'd2, 32'd3, 32'd7, 1'b0, readyCycle, busyCycles, pulses, res, err);
        checkOutput("after_abort_result", res, 6);
        checkOutput("after_abort_ready_cycle", readyCycle, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
